pagerank_reducer: RTL and testbench

//   Downstream stage of the PageRank mapper. Consumes the stream of mapper partial products
//   (r_i*g_i + r_j*g_j words) for one destination node and sums them into that node's new rank.
//   It emits one rank word per node. A cfg handshake gives the term count per node.
//   The in/out val/rdy handshakes let several mappers feed it through an arbiter, and let a

---
 rtl/pagerank_pkg.sv | 14 +
 rtl/pagerank_accum_reg.sv | 40 ++++
 rtl/pagerank_reducer.sv | 97 +++++++++
 tb/tb_pagerank_reducer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pagerank_pkg.sv
// Shared definitions for the PageRank pipeline stages.
// State encoding and default widths used by mapper, reducer and writeback.
package pagerank_pkg;

    localparam int NBITS_DEF = 32;
    localparam int CBITS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/pagerank_accum_reg.sv
// Accumulator register: clears to zero or adds an operand each cycle.
// Sum wraps modulo 2^nbits; carry out is dropped.
module pagerank_accum_reg
    import pagerank_pkg::*;
#(
    parameter int nbits = NBITS_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             add_en_i,
    input  logic [nbits-1:0] add_i,
    output logic [nbits-1:0] q_o
);

    logic [nbits-1:0] sum_q;
    logic [nbits-1:0] sum_d;

    // Next sum: clear has priority over add.
    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_en_i) begin
            sum_d = sum_q + add_i;
        end
    end

    // Sum register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign q_o = sum_q;

endmodule

// File: rtl/pagerank_reducer.sv
// Sums a configured number of mapper partial products into one rank word.
// One node in flight: IDLE takes a config, ACCUM sums terms, DONE presents the result.
module pagerank_reducer
    import pagerank_pkg::*;
#(
    parameter int nbits = NBITS_DEF,
    parameter int cbits = CBITS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [cbits-1:0] cfg_num,
    input  logic             cfg_val,
    output logic             cfg_rdy,
    input  logic [nbits-1:0] in_msg,
    input  logic             in_val,
    output logic             in_rdy,
    output logic [nbits-1:0] out_msg,
    output logic             out_val,
    input  logic             out_rdy
);

    state_e           state_q, state_d;
    logic [cbits-1:0] rem_q, rem_d;
    logic             clr;
    logic             add_en;
    logic [nbits-1:0] sum;

    // Next state, remaining count and handshake outputs.
    // Handshakes decode only the registered state, gated off while in reset.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        clr     = 1'b0;
        add_en  = 1'b0;
        cfg_rdy = 1'b0;
        in_rdy  = 1'b0;
        out_val = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cfg_rdy = reset;
                if (cfg_val && reset) begin
                    clr = 1'b1;
                    if (cfg_num == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        rem_d   = cfg_num;
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                in_rdy = reset;
                if (in_val && reset) begin
                    add_en = 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == cbits'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                out_val = reset;
                if (out_rdy && reset) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and remaining-term counter; reset drops any node in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    pagerank_accum_reg #(
        .nbits (nbits)
    ) u_sum (
        .clk_i    (clk),
        .rst_ni   (reset),
        .clr_i    (clr),
        .add_en_i (add_en),
        .add_i    (in_msg),
        .q_o      (sum)
    );

    assign out_msg = reset ? sum : '0;

endmodule

// File: tb/tb_pagerank_reducer.sv
// Randomized and directed checks of pagerank_reducer against a sum-of-terms model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pagerank_reducer;

    localparam int NB = 32;
    localparam int CB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CB-1:0] cfg_num = '0;
    logic          cfg_val = 1'b0;
    logic          cfg_rdy;
    logic [NB-1:0] in_msg = '0;
    logic          in_val = 1'b0;
    logic          in_rdy;
    logic [NB-1:0] out_msg;
    logic          out_val;
    logic          out_rdy = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [NB-1:0] terms_q[$];
    int            bub_q[$];
    bit            noise = 1'b0;

    pagerank_reducer #(
        .nbits (NB),
        .cbits (CB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cfg_num (cfg_num),
        .cfg_val (cfg_val),
        .cfg_rdy (cfg_rdy),
        .in_msg  (in_msg),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .out_msg (out_msg),
        .out_val (out_val),
        .out_rdy (out_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive random junk onto the non-accepting interfaces.
    task automatic junk_cfg();
        if (noise) begin
            cfg_val = 1'($urandom);
            cfg_num = CB'($urandom);
        end else begin
            cfg_val = 1'b0;
        end
    endtask

    // One node: terms_q holds the terms, bub_q the idle cycles before each.
    task automatic run_node(input string tag, input int bp);
        int            n;
        longint unsigned acc;
        logic [NB-1:0] exp;
        n   = terms_q.size();
        acc = 0;
        foreach (terms_q[i]) acc += 64'(terms_q[i]);
        exp = NB'(acc % (64'd1 << NB));

        check({tag, ".cfg_rdy"}, cfg_rdy, 1);
        check({tag, ".idle_outv"}, out_val, 0);
        cfg_val = 1'b1;
        cfg_num = CB'(n);
        tick();
        cfg_val = 1'b0;

        if (n == 0) begin
            check({tag, ".zero_inrdy"}, in_rdy, 0);
        end
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < bub_q[i]; b++) begin
                in_val = 1'b0;
                junk_cfg();
                tick();
                check({tag, ".bub_inrdy"}, in_rdy, 1);
            end
            junk_cfg();
            check({tag, ".inrdy"}, in_rdy, 1);
            check({tag, ".early_outv"}, out_val, 0);
            in_val = 1'b1;
            in_msg = terms_q[i];
            tick();
            in_val = 1'b0;
        end
        cfg_val = 1'b0;

        check({tag, ".outv"}, out_val, 1);
        check({tag, ".sum"}, out_msg, exp);
        for (int b = 0; b < bp; b++) begin
            out_rdy = 1'b0;
            if (noise) begin
                in_val = 1'($urandom);
                in_msg = $urandom;
            end
            junk_cfg();
            tick();
            check({tag, ".hold_outv"}, out_val, 1);
            check({tag, ".hold_sum"}, out_msg, exp);
            check({tag, ".hold_cfgrdy"}, cfg_rdy, 0);
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        cfg_val = 1'b0;
        check({tag, ".post_outv"}, out_val, 0);
        check({tag, ".post_cfgrdy"}, cfg_rdy, 1);
    endtask

    task automatic set_node(input int n);
        terms_q.delete();
        bub_q.delete();
        for (int i = 0; i < n; i++) begin
            bub_q.push_back(0);
        end
    endtask

    initial begin
        #1;
        reset = 1'b0;
        tick();
        tick();
        check("rst.cfg_rdy", cfg_rdy, 0);
        check("rst.in_rdy", in_rdy, 0);
        check("rst.out_val", out_val, 0);
        check("rst.out_msg", out_msg, 0);
        reset = 1'b1;
        #1;
        check("idle.cfg_rdy", cfg_rdy, 1);
        check("idle.in_rdy", in_rdy, 0);
        check("idle.out_msg", out_msg, 0);

        set_node(3);
        terms_q = '{32'd5, 32'd7, 32'd11};
        run_node("basic", 0);

        set_node(0);
        run_node("zero", 0);

        set_node(2);
        terms_q = '{32'hFFFF_FFFF, 32'h0000_0002};
        run_node("wrap", 0);

        set_node(2);
        terms_q = '{32'd4, 32'd6};
        bub_q[1] = 3;
        run_node("bp", 5);

        // Reset part-way through a node.
        cfg_val = 1'b1;
        cfg_num = 8'd4;
        tick();
        cfg_val = 1'b0;
        in_val  = 1'b1;
        in_msg  = 32'd100;
        tick();
        in_msg  = 32'd200;
        tick();
        in_val  = 1'b0;
        check("midrst.inrdy", in_rdy, 1);
        reset = 1'b0;
        #1;
        check("midrst.low_inrdy", in_rdy, 0);
        check("midrst.low_msg", out_msg, 0);
        tick();
        reset = 1'b1;
        #1;
        check("midrst.cfg_rdy", cfg_rdy, 1);
        check("midrst.out_val", out_val, 0);
        tick();
        check("midrst.out_val2", out_val, 0);
        set_node(1);
        terms_q = '{32'd9};
        run_node("afterrst", 0);

        // Terms offered while idle must not be summed.
        in_val = 1'b1;
        in_msg = 32'd50;
        tick();
        check("spur.inrdy", in_rdy, 0);
        tick();
        set_node(1);
        terms_q = '{32'd3};
        run_node("spur", 0);

        noise = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 60)
                                            : $urandom_range(0, 6);
            terms_q.delete();
            bub_q.delete();
            for (int i = 0; i < n; i++) begin
                terms_q.push_back(($urandom_range(0, 3) == 0)
                                  ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                  : $urandom);
                bub_q.push_back($urandom_range(0, 2));
            end
            run_node($sformatf("rnd%0d", k), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
